// File: rtl/dm_arbiter.sv
// Shares the data-memory port between the CPU and a DMA/debug master: round-robin, bounded DMA burst lock.
// Grant follows a request by >=1 cycle, each grant is one DM access, and c_stall holds the CPU until its grant.
// Optional DM_ARB_ALIGN_CHECK_EN: flag and suppress misaligned word writes via err.
module dm_arbiter #(
   parameter int MAX_BURST = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        c_req,
   input  logic        c_we,
   input  logic [1:0]  c_type,
   input  logic [31:0] c_addr,
   input  logic [31:0] c_wdata,
   input  logic [31:0] c_pc,
   output logic        c_gnt,
   output logic        c_stall,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [1:0]  d_type,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic        d_lock,
   output logic        d_gnt,
   output logic [31:0] rdata,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_data,
   output logic        dm_we,
   output logic [1:0]  dm_type,
   output logic [31:0] dm_pc,
   input  logic [31:0] dm_out,
   output logic        err
);

   typedef enum logic [1:0] {IDLE, OWN_C, OWN_D} state_t;

   localparam logic [3:0] MAX_B = 4'(MAX_BURST);

   state_t     state_q, state_d;
   logic       last_q, last_d;     // 1 = DMA was granted most recently
   logic [3:0] burst_q, burst_d;   // consecutive DMA grants, saturating at MAX_B
   logic       lock_cont;

   logic        own_req, own_we, owned, misalign;
   logic [1:0]  own_type;
   logic [31:0] own_addr, own_data, own_pc;

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      burst_d   = burst_q;
      lock_cont = (state_q == OWN_D) && d_req && d_lock && (burst_q < MAX_B);

      if (lock_cont)
         state_d = OWN_D;
      else if (c_req && d_req)
         state_d = last_q ? OWN_C : OWN_D;
      else if (c_req)
         state_d = OWN_C;
      else if (d_req)
         state_d = OWN_D;
      else
         state_d = IDLE;

      if (state_d == OWN_C)
         last_d = 1'b0;
      else if (state_d == OWN_D)
         last_d = 1'b1;

      if (state_d == OWN_D)
         burst_d = (burst_q == MAX_B) ? burst_q : burst_q + 4'd1;
      else
         burst_d = 4'd0;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         burst_q <= 4'd0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         burst_q <= burst_d;
      end
   end

   always_comb begin
      own_req  = 1'b0;
      own_we   = 1'b0;
      own_type = 2'd0;
      own_addr = 32'd0;
      own_data = 32'd0;
      own_pc   = 32'd0;
      case (state_q)
         OWN_C: begin
            own_req  = c_req;
            own_we   = c_we;
            own_type = c_type;
            own_addr = c_addr;
            own_data = c_wdata;
            own_pc   = c_pc;
         end
         OWN_D: begin
            own_req  = d_req;
            own_we   = d_we;
            own_type = d_type;
            own_addr = d_addr;
            own_data = d_wdata;
         end
         default: ;
      endcase
   end

   assign owned = (state_q != IDLE);

`ifdef DM_ARB_ALIGN_CHECK_EN
   assign misalign = owned && (own_type == 2'd0) && (own_addr[1:0] != 2'd0);
`else
   assign misalign = 1'b0;
`endif

   assign err     = misalign;
   assign c_gnt   = (state_q == OWN_C);
   assign d_gnt   = (state_q == OWN_D);
   assign c_stall = rst && c_req && !c_gnt;

   // A dropped req or a reset cycle must never produce a DM write.
   assign dm_we   = rst && own_req && own_we && !misalign;
   assign dm_addr = own_addr;
   assign dm_data = own_data;
   assign dm_type = own_type;
   assign dm_pc   = own_pc;
   assign rdata   = owned ? dm_out : 32'd0;

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-port arbiter and sequencer in front of the byte-addressable data memory (DM). It shares the single DM access port between the CPU MEM stage and a DMA/debug requester. It drives the DM address, data, write-enable and access type, and returns read data and grants. Round-robin ordering applies by default, with a bounded DMA burst lock, so the DM is never driven by two masters in the same cycle.

## Interface
- MAX_BURST, default 4 — maximum consecutive DMA grants under lock (1..15).
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  synchronous, active-low reset.
- c_req  in  1  CPU access request; held with all c_* fields until c_gnt.
- c_we  in  1  CPU write (1) / read (0).
- c_type  in  2  access width: 0 = word, 1 = byte.
- c_addr  in  32  CPU byte address.
- c_wdata  in  32  CPU store data.
- c_pc  in  32  PC of the issuing instruction, forwarded to the DM for the write log.
- c_gnt  out  1  CPU access performed this cycle.
- c_stall  out  1  equals c_req & ~c_gnt; freezes the CPU pipeline.
- d_req, d_we, d_type[2], d_addr[32], d_wdata[32]  in  DMA equivalents of the c_* fields.
- d_lock  in  1  DMA requests back-to-back grants.
- d_gnt  out  1  DMA access performed this cycle.
- rdata  out  32  DM read data, valid in the cycle the requester's gnt is high.
- dm_addr, dm_data  out  32 each  to DM.
- dm_we  out  1  to DM.
- dm_type  out  2  to DM.
- dm_pc  out  32  to DM (equals 0 for DMA accesses).
- dm_out  in  32  DM combinational read data.
- err  out  1  misaligned-access flag (see Configuration).

## Operation
- The FSM has three states: IDLE, OWN_C and OWN_D. c_gnt = (state == OWN_C); d_gnt = (state == OWN_D).
- When the DM is owned, the dm_* outputs mux the owner's fields. In IDLE, dm_we = 0 and the other dm_* outputs are 0.
- rdata = dm_out whenever either gnt is high; otherwise 0.
- Registered priority bit `last` holds the most recently granted requester and resets to DMA, so the CPU wins the first tie.
- Next-state selection from IDLE, OWN_C, or OWN_D without a lock continuation:
  - Only one request is active: grant that requester.
  - Both requests are active: grant the requester that is not `last`.
  - No request is active: go to IDLE.
- Every grant lasts exactly one cycle and performs exactly one DM access. Back-to-back grants are allowed; there is no forced IDLE gap.
- Burst lock: in OWN_D, if d_req & d_lock are high and burst count < MAX_BURST, the next state is OWN_D even if c_req is high.
  - The burst counter increments on each consecutive DMA grant.
  - It clears on any non-DMA state.
  - At MAX_BURST, the counter forces normal arbitration, and the CPU wins if it is requesting.
- A requester deasserting req while granted is a protocol violation. dm_we is gated by the owner's req, so no write occurs.
- Width rule: dm_type passes through unchanged. Types 2 and 3 are treated as byte.

## Timing
- Reset values: state = IDLE, last = DMA, burst count = 0, and all outputs = 0.
- Reset asserted mid-grant drops the grant on the next edge. A write in a cycle where rst is low is not issued (dm_we = 0).
- Request-to-grant latency is 1 cycle minimum. req sampled high at edge N gives gnt in cycle N+1 if that requester wins.
- Worst-case CPU wait under a saturating DMA lock is MAX_BURST+1 cycles.
- A DM write commits on the posedge ending the gnt cycle. Read data is combinational within the gnt cycle.

## Configuration
- DM_ARB_ALIGN_CHECK_EN defined:
  - A word access (type 0) with addr[1:0] != 0 asserts err during its gnt cycle.
  - dm_we is forced 0 for that access; the grant is still consumed.
- DM_ARB_ALIGN_CHECK_EN undefined: err is tied 0 and misaligned accesses pass through unchanged.

## Test plan
- Reset with both req high, rst low for 2 cycles: all outputs 0 throughout. First cycle after release (rst high): c_gnt = 1.
- CPU only, sw: c_addr = 0x10, c_wdata = 0xDEADBEEF. Cycle 1: c_stall = 1. Cycle 2: c_gnt = 1, dm_we = 1. A subsequent lw from 0x10 returns rdata = 0xDEADBEEF.
- Both requesting continuously without lock: grants alternate C, D, C, D. Each c_stall is exactly 1 cycle between CPU grants.
- DMA lock with MAX_BURST = 4 and CPU requesting: 4 consecutive d_gnt, then c_gnt, then DMA resumes.
- Reset asserted during OWN_D write cycle: DM contents at d_addr unchanged. state = IDLE after the edge.
- With DM_ARB_ALIGN_CHECK_EN: sw to 0x13 gives err = 1 and dm_we = 0 in the gnt cycle. Byte store to 0x13 gives err = 0 and writes.
